// File: rtl/maxpool_fifo_pkg.sv
// maxpool_fifo_pkg: shared types and constants for the maxpool FIFO controller
package maxpool_fifo_pkg;

    localparam int DATA_W           = 32;
    localparam int FIFO_DEPTH       = 16;
    localparam int PROG_FULL_THRESH = 10;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        SLEEP  = 2'd1,
        WAKE   = 2'd2
    } state_t;

endpackage

// File: rtl/maxpool_beat_cnt.sv
// maxpool_beat_cnt: wrapping beat counter 0..ROW_LEN-1 with terminal-count flag and early clear
module maxpool_beat_cnt #(
    parameter int ROW_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic tc
);

    localparam int W = $clog2(ROW_LEN);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc = cnt_q == W'(ROW_LEN - 1);

    // advance on each beat; a beat at terminal count or with clr returns to zero
    always_comb begin
        cnt_d = inc ? ((tc | clr) ? '0 : cnt_q + W'(1)) : cnt_q;
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/maxpool_fifo_ctrl.sv
// maxpool_fifo_ctrl: AXI-stream front end for an FWFT FIFO with row framing and idle sleep
// Optional sleep/wake power management is built when MAXPOOL_FIFO_CTRL_SLEEP_EN is defined.
module maxpool_fifo_ctrl
    import maxpool_fifo_pkg::*;
#(
    parameter int ROW_LEN     = 8,
    parameter int IDLE_CYCLES = 32,
    parameter int WAKE_CYCLES = 2
) (
    input  logic              wr_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] fifo_din,
    output logic              fifo_wr_en,
    output logic              fifo_rd_en,
    output logic              fifo_sleep,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    input  logic              fifo_prog_full,
    input  logic              fifo_data_valid,
    output logic [15:0]       row_cnt,
    output logic              len_err,
    output logic [1:0]        state_o
);

    if (ROW_LEN < 2 || ROW_LEN > 256 || IDLE_CYCLES < 1 || IDLE_CYCLES > 255 ||
        WAKE_CYCLES < 1 || WAKE_CYCLES > 15 || PROG_FULL_THRESH >= FIFO_DEPTH) begin : g_param_err
        $error("maxpool_fifo_ctrl: parameter out of range");
    end

    state_t      state_q, state_d;
    logic [15:0] row_cnt_q, row_cnt_d;
    logic        len_err_q, len_err_d;
    logic        active, in_tc, out_tc;

    // streaming is only allowed in ACTIVE and never while reset is held
    assign active        = (state_q == ACTIVE) & !rst;
    assign s_axis_tready = active & !fifo_prog_full & !fifo_full;
    assign fifo_wr_en    = s_axis_tvalid & s_axis_tready;
    assign fifo_din      = s_axis_tdata;
    assign m_axis_tvalid = fifo_data_valid & !fifo_empty & active;
    assign m_axis_tdata  = fifo_dout;
    assign fifo_rd_en    = m_axis_tvalid & m_axis_tready;
    assign m_axis_tlast  = m_axis_tvalid & out_tc;
    assign row_cnt       = row_cnt_q;
    assign len_err       = len_err_q;
    assign state_o       = state_q;

    maxpool_beat_cnt #(.ROW_LEN(ROW_LEN)) u_out_cnt (
        .clk (wr_clk),
        .rst (rst),
        .inc (fifo_rd_en),
        .clr (1'b0),
        .tc  (out_tc)
    );

    maxpool_beat_cnt #(.ROW_LEN(ROW_LEN)) u_in_cnt (
        .clk (wr_clk),
        .rst (rst),
        .inc (fifo_wr_en),
        .clr (s_axis_tlast),
        .tc  (in_tc)
    );

    // row counter and sticky framing error against the expected row length
    always_comb begin
        row_cnt_d = row_cnt_q + 16'(fifo_rd_en & m_axis_tlast);
        len_err_d = len_err_q | (fifo_wr_en & (s_axis_tlast != in_tc));
    end

    // status registers
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            row_cnt_q <= '0;
            len_err_q <= 1'b0;
        end else begin
            row_cnt_q <= row_cnt_d;
            len_err_q <= len_err_d;
        end
    end

`ifdef MAXPOOL_FIFO_CTRL_SLEEP_EN
    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic [3:0] wake_cnt_q, wake_cnt_d;
    logic       idle;

    // sleep is only ever entered with an empty FIFO and no pending input
    assign idle       = fifo_empty & !s_axis_tvalid;
    assign fifo_sleep = !rst & (state_q != ACTIVE);

    // next state: idle timeout into SLEEP, input request into WAKE, timed WAKE back to ACTIVE
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
        case (state_q)
            ACTIVE: begin
                idle_cnt_d = idle ? idle_cnt_q + 8'd1 : '0;
                if (idle && idle_cnt_q == 8'(IDLE_CYCLES - 1)) state_d = SLEEP;
            end
            SLEEP: if (s_axis_tvalid) state_d = WAKE;
            WAKE: begin
                wake_cnt_d = wake_cnt_q + 4'd1;
                if (wake_cnt_q == 4'(WAKE_CYCLES - 1)) state_d = ACTIVE;
            end
            default: state_d = ACTIVE;
        endcase
    end

    // state and timer registers
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            state_q    <= ACTIVE;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
        end
    end
`else
    assign fifo_sleep = 1'b0;

    // without power management the controller stays ACTIVE
    always_comb begin
        state_d = ACTIVE;
    end

    // state register
    always_ff @(posedge wr_clk) begin
        if (rst) state_q <= ACTIVE;
        else     state_q <= state_d;
    end
`endif

endmodule
